// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a DEPTH-entry FIFO feeds an 8N1 serializer on TX_Serial.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [7:0]        write_data,
  output logic              TX_Serial,
  output logic              TX_BUSY,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic              tx_q, tx_d;
  logic              baud_last;
  logic              push, pop;
  logic [7:0]        shreg;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;

  assign fifo_full  = (count == (ADDR_W+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_count = count;
  assign TX_Serial  = tx_q;
  assign TX_BUSY    = (state != IDLE);

  // Fullness is judged on the pre-edge count, so a push racing a pop while full is dropped.
  assign push      = write_enable && !fifo_full;
  assign baud_last = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (write_enable && fifo_full) overflow <= 1'b1;
    end
  end

  // Buffer storage and the frame byte carry no reset; they are only read once validated.
  always_ff @(posedge clk_100MHz) begin
    if (push) mem[wr_ptr] <= write_data;
    if (pop)  shreg <= mem[rd_ptr];
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      tx_q     <= tx_d;
    end
  end

  // The pin value is computed for the next state and registered, so TX_Serial never glitches.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          tx_d       = shreg[0];
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^shreg;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            tx_d      = shreg[3'(bit_idx + 3'd1)];
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = STOP;
          tx_d       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          tx_d       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: accepted bytes are queued and a line monitor decodes frames.
module tb_uart_tx_buffered;

  localparam int CPB    = 4;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              write_enable = 1'b0;
  logic [7:0]        write_data = 8'h00;
  logic              tx, busy, full, empty, ovf;
  logic [ADDR_W:0]   count;

  int       n_checks = 0;
  int       n_pass   = 0;
  int       cyc      = 0;
  logic     mon_en   = 1'b0;
  logic     last_par = 1'bx;
  logic [7:0] exp_q[$];
  int       start_q[$];

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .write_enable(write_enable),
    .write_data  (write_data),
    .TX_Serial   (tx),
    .TX_BUSY     (busy),
    .fifo_full   (full),
    .fifo_empty  (empty),
    .fifo_count  (count),
    .overflow    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples each bit at its first falling clock edge and checks against the scoreboard.
  initial begin : monitor
    logic prev;
    logic [7:0] b;
    logic stop_bit;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        start_q.push_back(cyc);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        last_par = tx;
        n_checks++;
        if (last_par !== ^b) $display("FAIL parity_bit: got %0b expected %0b (byte %02h)", last_par, ^b, b);
        else n_pass++;
`endif
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        n_checks++;
        if (stop_bit !== 1'b1) $display("FAIL stop_bit: got %0b expected 1", stop_bit);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL frame_unexpected: got %02h expected no frame", b);
        end else begin
          e = exp_q.pop_front();
          if (b !== e) $display("FAIL frame_data: got %02h expected %02h", b, e);
          else n_pass++;
        end
      end
      prev = tx;
    end
  end

  task automatic wait_idle(input string name, input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0 && empty === 1'b1) done = 1;
    end
    n_checks++;
    if (!done) $display("FAIL %s_drain: got %0d frames pending expected 0 within %0d cycles", name, exp_q.size(), bound);
    else n_pass++;
  endtask

  task automatic test_reset;
    int errs = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx, busy, count, empty, full, ovf} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got tx=%0b busy=%0b cnt=%0d empty=%0b full=%0b ovf=%0b expected 1 0 0 1 0 0",
               tx, busy, count, empty, full, ovf);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    write_enable = 1'b1; write_data = 8'hA5;
    @(negedge clk);
    write_data = 8'h3C;
    @(negedge clk);
    write_enable = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    n_checks++;
    if ({busy, count} !== {1'b1, 5'd1})
      $display("FAIL midframe_pre: got busy=%0b cnt=%0d expected busy=1 cnt=1", busy, count);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({tx, busy, count, ovf} !== {1'b1, 1'b0, 5'd0, 1'b0})
      $display("FAIL midframe_async: got tx=%0b busy=%0b cnt=%0d ovf=%0b expected 1 0 0 0", tx, busy, count, ovf);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3 * FB * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    n_checks++;
    if (errs != 0) $display("FAIL post_reset_idle: got %0d non-idle cycles expected 0", errs);
    else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    int busy_cyc = 0;
    @(negedge clk);
    write_enable = 1'b1; write_data = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    write_enable = 1'b0;
    n_checks++;
    if ({count, tx} !== {5'd1, 1'b1}) $display("FAIL single_push: got cnt=%0d tx=%0b expected cnt=1 tx=1", count, tx);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx, busy, count} !== {1'b0, 1'b1, 5'd0})
      $display("FAIL single_start: got tx=%0b busy=%0b cnt=%0d expected 0 1 0", tx, busy, count);
    else n_pass++;
    busy_cyc = 1;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
    end
    n_checks++;
    if (busy_cyc != FB * CPB) $display("FAIL single_busy_len: got %0d expected %0d", busy_cyc, FB * CPB);
    else n_pass++;
    wait_idle("single", 50);
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W:0] seen[3];
    start_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) seen[i-1] = count;
      write_enable = 1'b1; write_data = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
    end
    @(negedge clk);
    write_enable = 1'b0;
    seen[2] = count;
    n_checks++;
    if ({seen[0], seen[1], seen[2]} !== {5'd1, 5'd1, 5'd2})
      $display("FAIL burst_count: got %0d,%0d,%0d expected 1,1,2", seen[0], seen[1], seen[2]);
    else n_pass++;
    wait_idle("burst", 5 * FB * CPB);
    n_checks++;
    if (start_q.size() != 3) $display("FAIL burst_frames: got %0d expected 3", start_q.size());
    else if (start_q[1] - start_q[0] != FB * CPB + 1 || start_q[2] - start_q[1] != FB * CPB + 1)
      $display("FAIL burst_gap: got %0d,%0d expected %0d", start_q[1] - start_q[0], start_q[2] - start_q[1], FB * CPB + 1);
    else n_pass++;
  endtask

  task automatic test_overflow;
    int i;
    @(negedge clk);
    write_enable = 1'b1; write_data = 8'h11;
    exp_q.push_back(8'h11);
    @(negedge clk);
    write_enable = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      if (k == 16) begin
        n_checks++;
        if ({full, count, ovf} !== {1'b1, 5'd16, 1'b0})
          $display("FAIL full_at_16: got full=%0b cnt=%0d ovf=%0b expected 1 16 0", full, count, ovf);
        else n_pass++;
      end
      write_enable = 1'b1; write_data = 8'(8'h20 + k);
      if (k < 16) exp_q.push_back(8'(8'h20 + k));
      @(negedge clk);
    end
    write_enable = 1'b0;
    n_checks++;
    if ({full, count, ovf} !== {1'b1, 5'd16, 1'b1})
      $display("FAIL overflow_drop: got full=%0b cnt=%0d ovf=%0b expected 1 16 1", full, count, ovf);
    else n_pass++;
    for (i = 0; i < 4 * FB * CPB && busy !== 1'b0; i++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL overflow_wait_idle: got busy=%0b expected 0", busy);
    end else begin
      n_pass++;
      write_enable = 1'b1; write_data = 8'hEE;
      @(negedge clk);
      write_enable = 1'b0;
      n_checks++;
      if ({full, count, ovf} !== {1'b0, 5'd15, 1'b1})
        $display("FAIL push_pop_full: got full=%0b cnt=%0d ovf=%0b expected 0 15 1", full, count, ovf);
      else n_pass++;
    end
    wait_idle("overflow", 20 * (FB * CPB + 1));
    n_checks++;
    if (ovf !== 1'b1) $display("FAIL overflow_sticky: got %0b expected 1", ovf);
    else n_pass++;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] v[2];
    logic       p[2];
    v[0] = 8'h07; p[0] = 1'b1;
    v[1] = 8'h03; p[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      last_par = 1'bx;
      @(negedge clk);
      write_enable = 1'b1; write_data = v[k];
      exp_q.push_back(v[k]);
      @(negedge clk);
      write_enable = 1'b0;
      wait_idle("parity", 3 * FB * CPB);
      n_checks++;
      if (last_par !== p[k]) $display("FAIL parity_%02h: got %0b expected %0b", v[k], last_par, p[k]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
